// File: rtl/button_irq_ctrl.sv
// button_irq_ctrl: debounces active-low buttons, records press events per channel
// and presents them to the CPU one at a time on a single interrupt line.
// Build option: define BTN_PRESS_COUNT_EN to add saturating per-channel press
// counters on output press_cnt.
module button_irq_ctrl #(
  parameter int N_BTN      = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_BTN-1:0]   buttons,
  input  logic               irq_ack,
  output logic [N_BTN-1:0]   btn_state,
  output logic [N_BTN-1:0]   pending,
  output logic               irq,
  output logic [3:0]         irq_id
`ifdef BTN_PRESS_COUNT_EN
  ,
  output logic [N_BTN*8-1:0] press_cnt
`endif
);

  // Counter only has to reach DEB_CYCLES-1; the terminal sample toggles and clears.
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  // state  | meaning
  // IDLE   | no request outstanding, waiting for a pending bit
  // ASSERT | irq high for channel irq_id, waiting for irq_ack
  // GAP    | one forced low cycle after an ack
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_e;

  // The synchroniser stores the inverted (pressed = 1) level, so its reset
  // value of 0 means "released" and a button held through reset is seen as a
  // fresh press with the full synchroniser + debounce latency.
  logic [N_BTN-1:0]          sync1_q, sync2_q;
  logic [N_BTN-1:0]          btn_q, btn_d;
  logic [N_BTN-1:0]          pend_q, pend_d;
  logic [N_BTN-1:0]          rise;
  logic [N_BTN-1:0]          ack_vec;
  logic [N_BTN-1:0][CW-1:0]  cnt_q, cnt_d;
  logic                      ack_now;
  logic [3:0]                low_id;
  state_e                    state_q;
  logic                      irq_q;
  logic [3:0]                irq_id_q;

  assign ack_now = (state_q == ASSERT) && irq_ack;

  // Debounce: count consecutive samples that differ from the accepted level.
  always_comb begin
    btn_d = btn_q;
    cnt_d = cnt_q;
    rise  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2_q[i] != btn_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          btn_d[i] = ~btn_q[i];
          cnt_d[i] = '0;
          rise[i]  = ~btn_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Pending flags: ack clears the served channel, a new press wins over the clear.
  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < N_BTN; i++) begin
      ack_vec[i] = ack_now && (irq_id_q == 4'(i));
    end
    pend_d = (pend_q & ~ack_vec) | rise;
  end

  // Lowest-index pending channel.
  always_comb begin
    low_id = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend_q[i]) low_id = 4'(i);
    end
  end

  // Synchroniser, debounce state and pending flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      btn_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      sync1_q <= ~buttons;
      sync2_q <= sync1_q;
      btn_q   <= btn_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Request FSM with registered irq/irq_id. GAP also makes the IDLE decision,
  // so back-to-back requests are separated by exactly one low cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      case (state_q)
        IDLE, GAP: begin
          if (|pend_q) begin
            irq_id_q <= low_id;
            irq_q    <= 1'b1;
            state_q  <= ASSERT;
          end else begin
            state_q  <= IDLE;
          end
        end
        ASSERT: begin
          if (irq_ack) begin
            irq_q   <= 1'b0;
            state_q <= GAP;
          end
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign btn_state = btn_q;
  assign pending   = pend_q;
  assign irq       = irq_q;
  assign irq_id    = irq_id_q;

`ifdef BTN_PRESS_COUNT_EN
  logic [N_BTN-1:0][7:0] pcnt_q, pcnt_d;

  // Press counters: saturate at 255, restart from this edge's press on ack.
  always_comb begin
    pcnt_d = pcnt_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (ack_vec[i]) begin
        pcnt_d[i] = {7'd0, rise[i]};
      end else if (rise[i] && (pcnt_q[i] != 8'hFF)) begin
        pcnt_d[i] = pcnt_q[i] + 8'd1;
      end
    end
  end

  // Press counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pcnt_q <= '0;
    else        pcnt_q <= pcnt_d;
  end

  assign press_cnt = pcnt_q;
`endif

endmodule

// File: tb/tb_button_irq_ctrl.sv
// Directed bench for button_irq_ctrl (N_BTN=4, DEB_CYCLES=16, 60 ns clock).
// Expected values are queued when stimulus is applied and compared on pop.
module tb_button_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] buttons;
  logic       irq_ack;
  logic [3:0] btn_state;
  logic [3:0] pending;
  logic       irq;
  logic [3:0] irq_id;
`ifdef BTN_PRESS_COUNT_EN
  logic [31:0] press_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic irq_seen;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  button_irq_ctrl #(.N_BTN(4), .DEB_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .buttons   (buttons),
    .irq_ack   (irq_ack),
    .btn_state (btn_state),
    .pending   (pending),
    .irq       (irq),
    .irq_id    (irq_id)
`ifdef BTN_PRESS_COUNT_EN
    ,
    .press_cnt (press_cnt)
`endif
  );

  always #30 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic exp_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h expected <queued value>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      irq_seen = irq_seen | irq;
    end
  endtask

  task automatic press_release(input logic [3:0] pat);
    buttons = pat;
    step(18);
    buttons = 4'b1111;
    step(18);
  endtask

  initial begin
    reset    = 1'b0;
    buttons  = 4'b1111;
    irq_ack  = 1'b0;
    irq_seen = 1'b0;

    // Reset state, before any clock edge
    exp_push("rst_btn_state", 32'h0);
    exp_push("rst_pending",   32'h0);
    exp_push("rst_irq",       32'h0);
    exp_push("rst_irq_id",    32'h0);
    #5;
    chk(32'(btn_state));
    chk(32'(pending));
    chk(32'(irq));
    chk(32'(irq_id));
    #15 reset = 1'b1;
    step(5);

    // Single press on channel 0: state/pending at edge 18, irq at edge 19
    buttons = 4'b1110;
    exp_push("t1_btn_e17",   32'h0);
    exp_push("t1_btn_e18",   32'h1);
    exp_push("t1_pend_e18",  32'h1);
    exp_push("t1_irq_e18",   32'h0);
    exp_push("t1_irq_e19",   32'h1);
    exp_push("t1_id_e19",    32'h0);
    step(17); chk(32'(btn_state));
    step(1);  chk(32'(btn_state)); chk(32'(pending)); chk(32'(irq));
    step(1);  chk(32'(irq)); chk(32'(irq_id));
    irq_ack = 1'b1;
    exp_push("t1_irq_ack",   32'h0);
    exp_push("t1_pend_ack",  32'h0);
    exp_push("t1_btn_ack",   32'h1);
    step(1); chk(32'(irq)); chk(32'(pending)); chk(32'(btn_state));
    exp_push("t1_irq_gap",   32'h0);
    step(1); chk(32'(irq));
    irq_ack = 1'b0;
    step(9);
    buttons  = 4'b1111;
    irq_seen = 1'b0;
    exp_push("t1_rel_btn",   32'h0);
    exp_push("t1_rel_pend",  32'h0);
    exp_push("t1_rel_irq",   32'h0);
    step(20); chk(32'(btn_state)); chk(32'(pending)); chk(32'(irq_seen));

    // Glitch of 10 samples on channel 1 is ignored
    irq_seen = 1'b0;
    buttons  = 4'b1101;
    exp_push("t2_btn",  32'h0);
    exp_push("t2_pend", 32'h0);
    exp_push("t2_irq",  32'h0);
    step(10);
    buttons = 4'b1111;
    step(25); chk(32'(btn_state)); chk(32'(pending)); chk(32'(irq_seen));

    // Priority: channels 2 and 3 together
    buttons = 4'b0011;
    exp_push("t3_btn",      32'hC);
    exp_push("t3_pend",     32'hC);
    exp_push("t3_irq1",     32'h1);
    exp_push("t3_id1",      32'h2);
    step(18); chk(32'(btn_state)); chk(32'(pending));
    step(1);  chk(32'(irq)); chk(32'(irq_id));
    irq_ack = 1'b1;
    exp_push("t3_irq_gap",  32'h0);
    exp_push("t3_pend_a1",  32'h8);
    step(1); chk(32'(irq)); chk(32'(pending));
    irq_ack = 1'b0;
    exp_push("t3_irq2",     32'h1);
    exp_push("t3_id2",      32'h3);
    step(1); chk(32'(irq)); chk(32'(irq_id));
    irq_ack = 1'b1;
    exp_push("t3_pend_a2",  32'h0);
    step(1); chk(32'(pending));
    irq_ack = 1'b0;
    exp_push("t3_irq_idle", 32'h0);
    exp_push("t3_id_hold",  32'h3);
    step(1); chk(32'(irq)); chk(32'(irq_id));
    buttons = 4'b1111;
    step(22);

    // Collision: new press on channel 0 on the same edge as its ack
    buttons = 4'b1110;
    exp_push("t4_pend_p1",  32'h1);
    step(18); chk(32'(pending));
    buttons = 4'b1111;
    exp_push("t4_btn_rel",  32'h0);
    exp_push("t4_irq_held", 32'h1);
    step(18); chk(32'(btn_state)); chk(32'(irq));
    buttons = 4'b1110;
    exp_push("t4_btn_e53",  32'h0);
    step(17); chk(32'(btn_state));
    irq_ack = 1'b1;
    exp_push("t4_btn_col",  32'h1);
    exp_push("t4_pend_col", 32'h1);
    exp_push("t4_irq_col",  32'h0);
`ifdef BTN_PRESS_COUNT_EN
    exp_push("t4_cnt_col",  32'h1);
`endif
    step(1); chk(32'(btn_state)); chk(32'(pending)); chk(32'(irq));
`ifdef BTN_PRESS_COUNT_EN
    chk(32'(press_cnt[7:0]));
`endif
    irq_ack = 1'b0;
    exp_push("t4_irq_re",   32'h1);
    exp_push("t4_id_re",    32'h0);
    step(1); chk(32'(irq)); chk(32'(irq_id));
    irq_ack = 1'b1;
    exp_push("t4_pend_end", 32'h0);
    step(1); chk(32'(pending));
    irq_ack = 1'b0;
    buttons = 4'b1111;
    step(22);

`ifdef BTN_PRESS_COUNT_EN
    // Press counter on channel 1: merge of 3 presses, then saturation
    exp_push("t6_cnt3",     32'h3);
    exp_push("t6_pend3",    32'h2);
    exp_push("t6_id3",      32'h1);
    for (int p = 0; p < 3; p++) press_release(4'b1101);
    chk(32'(press_cnt[15:8])); chk(32'(pending)); chk(32'(irq_id));
    irq_ack = 1'b1;
    exp_push("t6_cnt_ack",  32'h0);
    exp_push("t6_pend_ack", 32'h0);
    step(1); chk(32'(press_cnt[15:8])); chk(32'(pending));
    irq_ack = 1'b0;
    step(2);
    exp_push("t6_cnt_sat",  32'hFF);
    for (int p = 0; p < 300; p++) press_release(4'b1101);
    chk(32'(press_cnt[15:8]));
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    step(3);
`endif

    // Reset while a request is active
    buttons = 4'b1011;
    exp_push("t5_irq_pre",  32'h1);
    step(19); chk(32'(irq));
    #10 reset = 1'b0;
    #1;
    exp_push("t5_irq_rst",  32'h0);
    exp_push("t5_pend_rst", 32'h0);
    exp_push("t5_btn_rst",  32'h0);
    exp_push("t5_id_rst",   32'h0);
    chk(32'(irq)); chk(32'(pending)); chk(32'(btn_state)); chk(32'(irq_id));
    buttons = 4'b1111;
    @(posedge clk); #1;
    reset    = 1'b1;
    irq_seen = 1'b0;
    exp_push("t5_irq_after", 32'h0);
    exp_push("t5_pend_after", 32'h0);
    step(25); chk(32'(irq_seen)); chk(32'(pending));

    // Button held through reset gives a fresh press after 18 edges
    buttons = 4'b1011;
    step(19);
    #10 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_push("t7_btn_e17",  32'h0);
    exp_push("t7_btn_e18",  32'h4);
    exp_push("t7_pend_e18", 32'h4);
    exp_push("t7_irq_e19",  32'h1);
    exp_push("t7_id_e19",   32'h2);
    step(17); chk(32'(btn_state));
    step(1);  chk(32'(btn_state)); chk(32'(pending));
    step(1);  chk(32'(irq)); chk(32'(irq_id));

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
